add_bias_ctrl: RTL

Layer sequencer for the three-stage add-bias/ReLU pipeline. It sits between the R/G/B convolution engines and the add pipeline, and is built around a per-filter bias register file. It paces conv results into the pipeline, presents the correct per-filter bias on each accepted beat, and counts pipeline results to generate feature-map write addresses. It also detects end of layer.

---
 rtl/add_bias_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/add_bias_ctrl.sv
// Layer sequencer for the add-bias/ReLU pipeline: paces conv beats in, presents
// the per-filter bias, and turns in-order pipeline results into write addresses.
module add_bias_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_FILTERS = 16,
  parameter int FMAP_PIXELS = 900,
  parameter int FW          = $clog2(NUM_FILTERS),
  parameter int AW          = $clog2(NUM_FILTERS*FMAP_PIXELS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [FW-1:0]         cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_bias,
  input  logic                  start,
  input  logic                  conv_valid,
  output logic                  conv_ready,
  output logic                  adder_valid,
  output logic [DATA_WIDTH-1:0] bias_out,
  input  logic                  adder_valid_out,
  output logic                  wr_en,
  output logic [AW-1:0]         wr_addr,
  output logic [FW-1:0]         wr_filter,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            dbg_state
);

  // Handshake: a conv beat transfers on a cycle where conv_valid && conv_ready;
  // conv_valid does not depend on conv_ready, and adder_valid marks that beat.

  localparam int PW = (FMAP_PIXELS > 1) ? $clog2(FMAP_PIXELS) : 1;
  localparam logic [PW-1:0] L_PIX_LAST  = PW'(FMAP_PIXELS - 1);
  localparam logic [FW-1:0] L_FILT_LAST = FW'(NUM_FILTERS - 1);
  localparam logic [AW:0]   L_TOTAL     = (AW+1)'(NUM_FILTERS * FMAP_PIXELS);
  localparam logic [AW:0]   L_TOTAL_M1  = (AW+1)'(NUM_FILTERS * FMAP_PIXELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [PW-1:0]         r_pix_cnt;
  logic [FW-1:0]         r_filt_cnt;
  logic [PW-1:0]         r_wr_pix;
  logic [FW-1:0]         r_wr_filt;
  logic [AW:0]           r_wr_cnt;
  logic [2:0]            r_inflight;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_bias_mem [NUM_FILTERS];

  logic w_active;
  logic w_accept;
  logic w_wr_en;
  logic w_err_ev;
  logic w_start;

  assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_accept = conv_valid && (r_state == S_RUN);
  assign w_start  = start && (r_state == S_IDLE);
  // A result with nothing in flight, or outside a layer, is a protocol error and is dropped.
  assign w_wr_en  = adder_valid_out && w_active && (r_inflight != 3'd0);
  assign w_err_ev = adder_valid_out && (!w_active || (r_inflight == 3'd0));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    conv_ready = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_RUN;
      end
      S_RUN: begin
        conv_ready = 1'b1;
        if (w_accept && (r_pix_cnt == L_PIX_LAST) && (r_filt_cnt == L_FILT_LAST))
          w_next = S_DRAIN;
      end
      S_DRAIN: begin
        // Leave on the cycle the final write is issued so done lands one cycle later.
        if ((r_wr_cnt == L_TOTAL) || (w_wr_en && (r_wr_cnt == L_TOTAL_M1)))
          w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_pix_cnt  <= '0;
      r_filt_cnt <= '0;
      r_wr_pix   <= '0;
      r_wr_filt  <= '0;
      r_wr_cnt   <= '0;
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        if (r_pix_cnt == L_PIX_LAST) begin
          r_pix_cnt  <= '0;
          r_filt_cnt <= (r_filt_cnt == L_FILT_LAST) ? '0 : r_filt_cnt + 1'b1;
        end else begin
          r_pix_cnt <= r_pix_cnt + 1'b1;
        end
      end
      if (w_wr_en) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
        if (r_wr_pix == L_PIX_LAST) begin
          r_wr_pix  <= '0;
          r_wr_filt <= r_wr_filt + 1'b1;
        end else begin
          r_wr_pix <= r_wr_pix + 1'b1;
        end
      end
      case ({w_accept, w_wr_en})
        2'b10:   r_inflight <= r_inflight + 3'd1;
        2'b01:   r_inflight <= r_inflight - 3'd1;
        default: r_inflight <= r_inflight;
      endcase
      if (w_err_ev) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FILTERS; i++) r_bias_mem[i] <= '0;
    end else if (cfg_we && (r_state == S_IDLE)) begin
      r_bias_mem[cfg_addr] <= cfg_bias;
    end
  end

  assign adder_valid = w_accept;
  assign bias_out    = r_bias_mem[r_filt_cnt];
  assign wr_en       = w_wr_en;
  assign wr_addr     = r_wr_cnt[AW-1:0];
  assign wr_filter   = r_wr_filt;
  assign err         = r_err;
  assign dbg_state   = r_state;

endmodule
